seg7_scan_mux: RTL and testbench

- Multiplexed 7-segment display driver; sits directly downstream of the clock divider and consumes its slow square-wave output as the digit-scan rate.
- Holds one hex nibble plus one decimal point per digit and scans the digits one at a time.
- Inserts an all-off blanking gap between digits to prevent ghosting.
- Double-buffers the display data so that a frame never shows a mix of old and new values.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_decoder.sv | 19 +
 rtl/seg7_scan_mux.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the multiplexed 7-segment scan driver:
//   - scan_state_t : scan FSM states (IDLE, SHOW, BLANK)
//   - SEG_OFF      : all segments dark (active-low)
//   - HEX_SEG_TABLE: hex digit 0-F to segment byte {DP,G,F,E,D,C,B,A},
//                    active-low, DP bit held off (1). Entry n sits at [n].
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
// Combinational hex-nibble to 7-segment decoder.
// Ports:
//   nibble in  4  hex value to display
//   dot    in  1  decimal point, active-high
//   seg    out 8  segments, active-low, {DP,G,F,E,D,C,B,A}
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    output logic [7:0] seg
);

    always_comb begin
        seg = {~dot, HEX_SEG_TABLE[nibble][6:0]};
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Multiplexed 7-segment display driver. SCAN_CLK (a slow square wave from
// the clock divider) is synchronised and edge-detected into scan_tick; each
// tick moves the display from one digit to an all-off blanking gap of
// BLANK_CYCLES clocks and then on to the next digit. Display data is double
// buffered: LOAD fills a pending buffer which is copied to the display buffer
// only when the scan wraps from the last digit back to digit 0.
//
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, zero digits with
// only zeros above them are shown dark (DP still honoured); digit 0 is never
// suppressed. When undefined every digit is decoded normally.
//
// Ports:
//   CLK           in  1             system clock
//   RESET         in  1             asynchronous reset, active-low
//   SCAN_CLK      in  1             scan-rate square wave (sampled as data)
//   DIGITS_IN     in  4*NUM_DIGITS  hex nibbles, digit 0 in [3:0]
//   DOTS_IN       in  NUM_DIGITS    decimal points, active-high
//   LOAD          in  1             one-cycle strobe capturing DIGITS_IN/DOTS_IN
//   DIGIT_SEL_OUT out NUM_DIGITS    anode enables, active-low
//   SEG_OUT       out 8             segments, active-low, {DP,G,F,E,D,C,B,A}
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    SCAN_CLK,
    input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
    input  logic [NUM_DIGITS-1:0]   DOTS_IN,
    input  logic                    LOAD,
    output logic [NUM_DIGITS-1:0]   DIGIT_SEL_OUT,
    output logic [7:0]              SEG_OUT
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    // Synchroniser and rising-edge detect
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_last_reg;
    logic                   scan_tick;

    // Scan FSM state
    scan_state_t            state_reg,     state_next;
    logic [IDX_W-1:0]       index_reg,     index_next;
    logic [CNT_W-1:0]       blank_cnt_reg, blank_cnt_next;
    logic                   frame_wrap;

    // Display and pending buffers
    logic [NUM_DIGITS-1:0][3:0] disp_nib_reg,  disp_nib_next;
    logic [NUM_DIGITS-1:0]      disp_dot_reg,  disp_dot_next;
    logic [NUM_DIGITS-1:0][3:0] pend_nib_reg,  pend_nib_next;
    logic [NUM_DIGITS-1:0]      pend_dot_reg,  pend_dot_next;
    logic                       pend_valid_reg, pend_valid_next;

    // Registered outputs
    logic [NUM_DIGITS-1:0] sel_reg, sel_next;
    logic [7:0]            seg_reg, seg_next;

    logic [3:0] show_nib;
    logic       show_dot;
    logic [7:0] dec_seg;
    logic       suppress;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_reg      <= '0;
            sync_last_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], SCAN_CLK};
            sync_last_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign scan_tick = sync_reg[SYNC_STAGES-1] & ~sync_last_reg;

    // Next-state logic. The buffer transfer happens on the same edge that
    // takes the index from the last digit back to 0; a LOAD on that edge is
    // applied after the transfer so it lands in pending for the next frame.
    always_comb begin
        state_next      = state_reg;
        index_next      = index_reg;
        blank_cnt_next  = blank_cnt_reg;
        frame_wrap      = 1'b0;
        disp_nib_next   = disp_nib_reg;
        disp_dot_next   = disp_dot_reg;
        pend_nib_next   = pend_nib_reg;
        pend_dot_next   = pend_dot_reg;
        pend_valid_next = pend_valid_reg;

        unique case (state_reg)
            IDLE: begin
                if (scan_tick) begin
                    state_next = SHOW;
                    index_next = '0;
                end
            end
            SHOW: begin
                if (scan_tick) begin
                    state_next     = BLANK;
                    blank_cnt_next = BLANK_LOAD;
                end
            end
            BLANK: begin
                // scan_tick is deliberately ignored here
                if (blank_cnt_reg == '0) begin
                    state_next = SHOW;
                    if (index_reg == LAST_IDX) begin
                        index_next = '0;
                        frame_wrap = 1'b1;
                    end else begin
                        index_next = index_reg + 1'b1;
                    end
                end else begin
                    blank_cnt_next = blank_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (frame_wrap && pend_valid_reg) begin
            disp_nib_next   = pend_nib_reg;
            disp_dot_next   = pend_dot_reg;
            pend_valid_next = 1'b0;
        end

        if (LOAD) begin
            pend_nib_next   = DIGITS_IN;
            pend_dot_next   = DOTS_IN;
            pend_valid_next = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the FSM, including the freshly transferred frame at a wrap.
    assign show_nib = disp_nib_next[index_next];
    assign show_dot = disp_dot_next[index_next];

    seg7_decoder u_decoder (
        .nibble (show_nib),
        .dot    (show_dot),
        .seg    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[gi]: digit gi and every digit above it are zero
    logic [NUM_DIGITS-1:0] lead_zero;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
            if (gi == 0) begin : g_units
                assign lead_zero[gi] = 1'b0;
            end else begin : g_upper
                assign lead_zero[gi] = (disp_nib_next[NUM_DIGITS-1:gi] == '0);
            end
        end
    endgenerate
    assign suppress = lead_zero[index_next];
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        sel_next = '1;
        seg_next = SEG_OFF;
        if (state_next == SHOW) begin
            sel_next = ~(NUM_DIGITS'(1) << index_next);
            seg_next = suppress ? {dec_seg[7], SEG_OFF[6:0]} : dec_seg;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg      <= IDLE;
            index_reg      <= '0;
            blank_cnt_reg  <= '0;
            disp_nib_reg   <= '0;
            disp_dot_reg   <= '0;
            pend_nib_reg   <= '0;
            pend_dot_reg   <= '0;
            pend_valid_reg <= 1'b0;
            sel_reg        <= '1;
            seg_reg        <= SEG_OFF;
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            blank_cnt_reg  <= blank_cnt_next;
            disp_nib_reg   <= disp_nib_next;
            disp_dot_reg   <= disp_dot_next;
            pend_nib_reg   <= pend_nib_next;
            pend_dot_reg   <= pend_dot_next;
            pend_valid_reg <= pend_valid_next;
            sel_reg        <= sel_next;
            seg_reg        <= seg_next;
        end
    end

    assign DIGIT_SEL_OUT = sel_reg;
    assign SEG_OUT       = seg_reg;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux. A frame-level reference model
// predicts which digit each scan step shows and pushes it into a queue; an
// independent monitor pops an entry whenever a digit lights up and also
// checks blanking gaps and hold stability.
module tb_seg7_scan_mux;

    localparam int N    = 4;
    localparam int BC   = 16;
    localparam int SS   = 2;
    localparam int HALF = 40;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SCAN_CLK;
    logic [15:0] DIGITS_IN;
    logic [3:0]  DOTS_IN;
    logic        LOAD;
    logic [3:0]  DIGIT_SEL_OUT;
    logic [7:0]  SEG_OUT;

    seg7_scan_mux #(.NUM_DIGITS(N), .BLANK_CYCLES(BC), .SYNC_STAGES(SS)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .SCAN_CLK      (SCAN_CLK),
        .DIGITS_IN     (DIGITS_IN),
        .DOTS_IN       (DOTS_IN),
        .LOAD          (LOAD),
        .DIGIT_SEL_OUT (DIGIT_SEL_OUT),
        .SEG_OUT       (SEG_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state
    int         step_s = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_dots = '0, m_pdots = '0;
    bit          m_pv = 1'b0;

    function automatic logic [7:0] model_seg(int i);
        int  nib;
        bit  dot;
        logic [7:0] s;
        nib = int'((m_disp >> (4 * i)) & 16'hF);
        dot = m_dots[i];
        s   = hex_tbl[nib];
        if (dot) s = s & 8'h7F;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (m_disp >> (4 * i)) == 16'h0) s = dot ? 8'h7F : 8'hFF;
`endif
        return s;
    endfunction

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        DIGITS_IN = d;
        DOTS_IN   = p;
        LOAD      = 1'b1;
        @(posedge CLK); #2;
        LOAD      = 1'b0;
        m_pend  = d;
        m_pdots = p;
        m_pv    = 1'b1;
    endtask

    // One SCAN_CLK period. The model predicts the digit shown after it.
    task automatic do_step(input bit wrap_load, input logic [15:0] wd,
                           input logic [3:0] wdots, input bit blank_tick);
        int   idx;
        exp_t e;
        idx = step_s % N;
        if (step_s >= 1 && idx == 0 && m_pv) begin
            m_disp = m_pend;
            m_dots = m_pdots;
            m_pv   = 1'b0;
        end
        e.sel = 4'hF;
        e.sel[idx] = 1'b0;
        e.seg = model_seg(idx);
        exp_q.push_back(e);
        if (wrap_load) begin
            m_pend  = wd;
            m_pdots = wdots;
            m_pv    = 1'b1;
        end
        step_s++;

        DIGITS_IN = 16'($urandom);
        DOTS_IN   = 4'($urandom);
        SCAN_CLK  = 1'b1;
        for (int c = 1; c <= 2 * HALF; c++) begin
            @(posedge CLK); #2;
            if (c == HALF) SCAN_CLK = 1'b0;
            if (blank_tick && c == 2) SCAN_CLK = 1'b0;
            if (blank_tick && c == 5) SCAN_CLK = 1'b1;
            if (wrap_load && c == SS + BC) begin
                DIGITS_IN = wd;
                DOTS_IN   = wdots;
                LOAD      = 1'b1;
            end
            if (wrap_load && c == SS + BC + 1) LOAD = 1'b0;
        end
    endtask

    // Monitor: sampled 1 time unit after every rising edge
    initial begin
        bit         in_show = 1'b0;
        bit         had_show = 1'b0;
        int         off_run = 0;
        logic [7:0] cur_seg = 8'hFF;
        logic [3:0] cur_sel = 4'hF;
        exp_t       e;
        forever begin
            @(posedge CLK); #1;
            if (!RESET) begin
                in_show = 1'b0; had_show = 1'b0; off_run = 0;
            end else if (DIGIT_SEL_OUT == 4'hF) begin
                checks++;
                if (SEG_OUT !== 8'hFF) begin
                    errors++;
                    $display("FAIL blank_seg: seg=%h required FF at %0t", SEG_OUT, $time);
                end
                in_show = 1'b0;
                off_run++;
            end else if (!in_show) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_digit: sel=%b seg=%h with no digit expected", DIGIT_SEL_OUT, SEG_OUT);
                end else begin
                    e = exp_q.pop_front();
                    if (DIGIT_SEL_OUT !== e.sel || SEG_OUT !== e.seg) begin
                        errors++;
                        $display("FAIL digit: sel=%b seg=%h required sel=%b seg=%h", DIGIT_SEL_OUT, SEG_OUT, e.sel, e.seg);
                    end else begin
                        $display("digit ok: sel=%b seg=%h", DIGIT_SEL_OUT, SEG_OUT);
                    end
                end
                if (had_show) begin
                    checks++;
                    if (off_run != BC) begin
                        errors++;
                        $display("FAIL blank_gap: %0d cycles required %0d", off_run, BC);
                    end
                end
                in_show = 1'b1; had_show = 1'b1; off_run = 0;
                cur_seg = SEG_OUT; cur_sel = DIGIT_SEL_OUT;
            end else begin
                checks++;
                if (SEG_OUT !== cur_seg || DIGIT_SEL_OUT !== cur_sel) begin
                    errors++;
                    $display("FAIL hold: sel=%b seg=%h required sel=%b seg=%h", DIGIT_SEL_OUT, SEG_OUT, cur_sel, cur_seg);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        RESET = 1'b0; SCAN_CLK = 1'b0; LOAD = 1'b0; DIGITS_IN = '0; DOTS_IN = '0;

        // Reset state
        repeat (3) @(posedge CLK); #1;
        checks++;
        if (DIGIT_SEL_OUT !== 4'hF || SEG_OUT !== 8'hFF) begin
            errors++;
            $display("FAIL reset_out: sel=%b seg=%h required sel=1111 seg=FF", DIGIT_SEL_OUT, SEG_OUT);
        end
        #1 RESET = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #2;
            if (DIGIT_SEL_OUT !== 4'hF || SEG_OUT !== 8'hFF) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_hold: %0d active cycles required 0", bad);
        end
        $display("reset check done");

        // Basic scan and tearing protection (load lands while digit 2 shows)
        do_load(16'h3A10, 4'b0010);
        for (int i = 0; i <= 10; i++) do_step(1'b0, '0, '0, 1'b0);
        do_load(16'h1111, 4'b0000);
        for (int i = 0; i < 6; i++) do_step(1'b0, '0, '0, 1'b0);

        // LOAD on the wrap edge with a value already pending
        while (step_s % N != 0) do_step(1'b0, '0, '0, 1'b0);
        do_load(16'h5555, 4'b0000);
        do_step(1'b1, 16'h8888, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) do_step(1'b0, '0, '0, 1'b0);

        // Tick arriving inside a blanking gap
        do_step(1'b0, '0, '0, 1'b1);
        do_step(1'b0, '0, '0, 1'b0);
        do_step(1'b0, '0, '0, 1'b0);

        // Randomized loads, sometimes several within one frame
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 2) == 0) do_load(16'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) do_load(16'($urandom), 4'($urandom));
            do_step(1'b0, '0, '0, 1'b0);
        end

        // Leading zeros
        do_load(16'h0070, 4'b0000);
        for (int i = 0; i < 8; i++) do_step(1'b0, '0, '0, 1'b0);

        // Reset asserted mid-digit blanks the outputs at once
        #2 RESET = 1'b0;
        #1;
        checks++;
        if (DIGIT_SEL_OUT !== 4'hF || SEG_OUT !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset: sel=%b seg=%h required sel=1111 seg=FF", DIGIT_SEL_OUT, SEG_OUT);
        end
        repeat (3) @(posedge CLK); #2;
        RESET = 1'b1;
        exp_q.delete();
        step_s = 0; m_disp = '0; m_dots = '0; m_pend = '0; m_pdots = '0; m_pv = 1'b0;
        repeat (30) @(posedge CLK); #2;
        do_step(1'b0, '0, '0, 1'b0);

        // Drain
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d digits never shown, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
